// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the common data bus.
// Grants at most one functional-unit requester per cycle (combinational ack),
// registers the winner's ROB tag and value, and broadcasts them on the next
// cycle. Requester 0 (load/store buffer) has an age-based starvation override.
module cdb_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int data_width = 16,
    parameter int tag_width  = 3
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            flush,
    input  logic                            cdb_hold,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*tag_width-1:0]    req_tag,
    input  logic [NUM_REQ*data_width-1:0]   req_value,
    output logic [NUM_REQ-1:0]              req_ack,
    output logic                            cdb_valid,
    output logic [tag_width-1:0]            cdb_tag,
    output logic [data_width-1:0]           cdb_value,
    output logic [$clog2(NUM_REQ)-1:0]      cdb_src
);

    localparam int SRC_W = $clog2(NUM_REQ);
    localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);

    logic [SRC_W-1:0]      rr_ptr;
    logic [SRC_W-1:0]      win_idx;
    logic [SRC_W-1:0]      cand;
    logic [SRC_W-1:0]      next_ptr;
    logic [1:0]            age;
    logic                  found;
    logic                  grant;
    logic [tag_width-1:0]  win_tag;
    logic [data_width-1:0] win_value;

    // Winner search from rr_ptr with wrap, starvation override, and grant gating
    always_comb begin
        found     = 1'b0;
        win_idx   = '0;
        cand      = '0;
        req_ack   = '0;
        if (age == 2'd3 && req_valid[0]) begin
            found = 1'b1;
        end else begin
            for (int unsigned off = 0; off < NUM_REQ; off++) begin
                cand = SRC_W'((32'(rr_ptr) + off) % NUM_REQ);
                if (!found && req_valid[cand]) begin
                    found   = 1'b1;
                    win_idx = cand;
                end
            end
        end
        grant = found && reset_n && !flush && !cdb_hold;
        if (grant) begin
            req_ack[win_idx] = 1'b1;
        end
        win_tag   = req_tag[win_idx*tag_width +: tag_width];
        win_value = req_value[win_idx*data_width +: data_width];
        next_ptr  = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
    end

    // Broadcast register and round-robin pointer; flush beats hold beats grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_src   <= '0;
            rr_ptr    <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (cdb_hold) begin
            cdb_valid <= cdb_valid;
        end else if (grant) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= win_tag;
            cdb_value <= win_value;
            cdb_src   <= win_idx;
            rr_ptr    <= next_ptr;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

    // Saturating wait counter for requester 0, cleared when it is served or on flush
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            age <= '0;
        end else if (flush || req_ack[0]) begin
            age <= '0;
        end else if (req_valid[0] && age != 2'd3) begin
            age <= age + 2'd1;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table-driven, hand-sequenced and randomized checks of cdb_arbiter
// against a behavioural model of the round-robin CDB arbitration rules.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int TW = 3;

    logic              clk;
    logic              reset_n;
    logic              flush;
    logic              cdb_hold;
    logic [N-1:0]      req_valid;
    logic [N*TW-1:0]   req_tag;
    logic [N*DW-1:0]   req_value;
    logic [N-1:0]      req_ack;
    logic              cdb_valid;
    logic [TW-1:0]     cdb_tag;
    logic [DW-1:0]     cdb_value;
    logic [1:0]        cdb_src;

    cdb_arbiter #(.NUM_REQ(N), .data_width(DW), .tag_width(TW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .cdb_hold  (cdb_hold),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_value (req_value),
        .req_ack   (req_ack),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
        .cdb_src   (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Fixed per-requester tag/value sets used by the table and hand sequences
    localparam logic [N*TW-1:0] FIX_TAGS = {3'd6, 3'd5, 3'd4, 3'd3};
    localparam logic [N*DW-1:0] FIX_VALS = {16'hD333, 16'h1234, 16'hB111, 16'hA000};
    logic [DW-1:0] fix_val_arr [N];
    initial begin
        fix_val_arr[0] = 16'hA000;
        fix_val_arr[1] = 16'hB111;
        fix_val_arr[2] = 16'h1234;
        fix_val_arr[3] = 16'hD333;
    end

    // Behavioural model state
    int            m_ptr;
    int            m_age;
    logic          m_valid;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_value;
    int            m_src;

    task automatic model_reset();
        m_ptr = 0; m_age = 0; m_valid = 1'b0; m_tag = '0; m_value = '0; m_src = 0;
    endtask

    function automatic int model_winner(input logic [N-1:0] v);
        int order[$];
        if (m_age == 3 && v[0]) return 0;
        for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
        foreach (order[j]) if (v[order[j]]) return order[j];
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ack(input logic [N-1:0] v, input logic f, input logic h);
        int w;
        w = model_winner(v);
        if (f || h || w < 0) return '0;
        return N'(1) << w;
    endfunction

    task automatic model_edge(input logic [N-1:0] v, input logic f, input logic h,
                              input logic [N*TW-1:0] tg, input logic [N*DW-1:0] vl);
        int w;
        logic won0;
        w = model_winner(v);
        won0 = !f && !h && (w == 0);
        if (f) m_valid = 1'b0;
        else if (h) begin end
        else if (w >= 0) begin
            m_valid = 1'b1;
            m_tag   = tg[w*TW +: TW];
            m_value = vl[w*DW +: DW];
            m_src   = w;
            m_ptr   = (w + 1) % N;
        end else m_valid = 1'b0;
        if (f || won0) m_age = 0;
        else if (v[0]) m_age = (m_age < 3) ? m_age + 1 : 3;
    endtask

    logic [N-1:0] samp_ack;
    logic [N-1:0] exp_ack;

    // Entered at posedge+1; drive, sample ack, advance one edge, leave at posedge+1
    task automatic step(input logic [N-1:0] v, input logic f, input logic h,
                        input logic [N*TW-1:0] tg, input logic [N*DW-1:0] vl);
        req_valid = v; flush = f; cdb_hold = h; req_tag = tg; req_value = vl;
        #1;
        samp_ack = req_ack;
        exp_ack  = model_ack(v, f, h);
        @(posedge clk);
        model_edge(v, f, h, tg, vl);
        #1;
    endtask

    task automatic do_reset();
        req_valid = 4'b1111; flush = 1'b0; cdb_hold = 1'b0;
        req_tag = FIX_TAGS; req_value = FIX_VALS;
        reset_n = 1'b0;
        #1;
        chk("rst_ack", req_ack, 0);
        chk("rst_valid", cdb_valid, 0);
        chk("rst_tag", cdb_tag, 0);
        chk("rst_value", cdb_value, 0);
        chk("rst_src", cdb_src, 0);
        @(negedge clk);
        req_valid = '0;
        reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [N-1:0] v;
        logic         f;
        logic         h;
        logic [N-1:0] ack;
        logic         val;
        int           src;
    } vec_t;

    vec_t tbl [15];

    task automatic check_fixed(input string pfx, input logic [N-1:0] ack,
                               input logic val, input int src);
        chk({pfx, "_ack"}, samp_ack, ack);
        chk({pfx, "_valid"}, cdb_valid, val);
        chk({pfx, "_src"}, cdb_src, src);
        chk({pfx, "_tag"}, cdb_tag, 3 + src);
        chk({pfx, "_value"}, cdb_value, fix_val_arr[src]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int got_cycle;
        reset_n = 1'b0;

        tbl[0]  = '{4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 2};
        tbl[1]  = '{4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 3};
        tbl[2]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 0};
        tbl[3]  = '{4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 1};
        tbl[4]  = '{4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 2};
        tbl[5]  = '{4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 3};
        tbl[6]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 0};
        tbl[7]  = '{4'b0011, 1'b0, 1'b1, 4'b0000, 1'b1, 0};
        tbl[8]  = '{4'b0011, 1'b0, 1'b1, 4'b0000, 1'b1, 0};
        tbl[9]  = '{4'b0011, 1'b0, 1'b0, 4'b0010, 1'b1, 1};
        tbl[10] = '{4'b0011, 1'b1, 1'b0, 4'b0000, 1'b0, 1};
        tbl[11] = '{4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 0};
        tbl[12] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 0};
        tbl[13] = '{4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 0};
        tbl[14] = '{4'b1010, 1'b0, 1'b0, 4'b0010, 1'b1, 1};

        do_reset();

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].v, tbl[i].f, tbl[i].h, FIX_TAGS, FIX_VALS);
            check_fixed($sformatf("tbl%0d", i), tbl[i].ack, tbl[i].val, tbl[i].src);
        end

        // Continuous requests from pointer 0 rotate 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b0, 1'b0, FIX_TAGS, FIX_VALS);
            check_fixed($sformatf("rr%0d", i), N'(1) << (i % 4), 1'b1, i % 4);
        end

        // Requester 0 starting behind the pointer is served by its 4th cycle
        do_reset();
        step(4'b0001, 1'b0, 1'b0, FIX_TAGS, FIX_VALS);
        check_fixed("starve_pre", 4'b0001, 1'b1, 0);
        got_cycle = 0;
        for (int k = 1; k <= 6 && got_cycle == 0; k++) begin
            step(4'b1111, 1'b0, 1'b0, FIX_TAGS, FIX_VALS);
            if (samp_ack[0]) got_cycle = k;
        end
        chk("starve_cycle", got_cycle, 4);

        // Asynchronous reset between edges during a broadcast
        do_reset();
        step(4'b1111, 1'b0, 1'b0, FIX_TAGS, FIX_VALS);
        check_fixed("arst_pre", 4'b0001, 1'b1, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", cdb_valid, 0);
        chk("arst_ack", req_ack, 0);
        chk("arst_src", cdb_src, 0);
        req_valid = '0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step(4'b1001, 1'b0, 1'b0, FIX_TAGS, FIX_VALS);
        check_fixed("arst_post", 4'b0001, 1'b1, 0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0]    rv;
            logic            rf;
            logic            rh;
            logic [N*TW-1:0] rt;
            logic [N*DW-1:0] rvl;
            rv  = N'($urandom_range(0, 15));
            rf  = ($urandom_range(0, 11) == 0);
            rh  = ($urandom_range(0, 5) == 0);
            rt  = N*TW'($urandom);
            rvl = {$urandom, $urandom};
            step(rv, rf, rh, rt, rvl);
            chk("rnd_ack", samp_ack, exp_ack);
            chk("rnd_valid", cdb_valid, m_valid);
            chk("rnd_tag", cdb_tag, m_tag);
            chk("rnd_value", cdb_value, m_value);
            chk("rnd_src", cdb_src, m_src);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
